// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//
// Contents:
//   - word and byte width constants;
//   - the responder FSM state type;
//   - the latched request record;
//   - address-window helpers used by the responder and its elaboration checks.
package dmem_pkg;

    localparam int unsigned WORD_BITS      = 32;
    localparam int unsigned BYTE_BITS      = 8;
    localparam int unsigned BYTES_PER_WORD = WORD_BITS / BYTE_BITS;

    // Wait-state counter width; WAIT_CYCLES must fit in it.
    localparam int unsigned WAIT_CNT_BITS  = 4;
    localparam int unsigned WAIT_MAX       = (1 << WAIT_CNT_BITS) - 1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWait   = 2'd1,
        StAccess = 2'd2,
        StResp   = 2'd3
    } dmem_state_e;

    typedef struct packed {
        logic                      we;
        logic [WORD_BITS-1:0]      addr;
        logic [WORD_BITS-1:0]      wdata;
        logic [BYTES_PER_WORD-1:0] be;
    } dmem_req_t;

    // First byte address past the window, kept 33 bits wide so a window that
    // ends exactly at 2^32 is representable and a wrapping one is detectable.
    function automatic logic [WORD_BITS:0] region_end(input logic [WORD_BITS-1:0] base,
                                                      input int unsigned depth_log2);
        return {1'b0, base} + ((WORD_BITS + 1)'(BYTES_PER_WORD) << depth_log2);
    endfunction

    // True when addr lies in [base, base + 4 * 2^depth_log2).
    function automatic logic addr_in_range(input logic [WORD_BITS-1:0] addr,
                                           input logic [WORD_BITS-1:0] base,
                                           input int unsigned depth_log2);
        return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < region_end(base, depth_log2));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM with per-byte write enables.
//
// Ports:
//   clk    in   clock, all activity on the rising edge
//   en     in   port enable; read data only updates on enabled cycles
//   wen    in   per-byte write enables (bit i covers wdata[8i+7:8i])
//   addr   in   word index
//   wdata  in   write data
//   rdata  out  registered read data (old contents when reading and writing
//               the same word in one cycle)
//
// There is no reset: contents survive the responder's reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                      clk,
    input  logic                      en,
    input  logic [BYTES_PER_WORD-1:0] wen,
    input  logic [DEPTH_LOG2-1:0]     addr,
    input  logic [WORD_BITS-1:0]      wdata,
    output logic [WORD_BITS-1:0]      rdata
);

    localparam int unsigned NUM_WORDS = 1 << DEPTH_LOG2;

    logic [WORD_BITS-1:0] mem [NUM_WORDS];
    logic [WORD_BITS-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                if (wen[i]) begin
                    mem[addr][i*BYTE_BITS +: BYTE_BITS] <= wdata[i*BYTE_BITS +: BYTE_BITS];
                end
            end
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: target side of the core's load/store interface.
//
// Accepts one request at a time, idles for WAIT_CYCLES wait states, performs
// a byte-enabled store or a word load on a private RAM, then holds the
// response until the core takes it. Requests never overlap.
//
// Ports:
//   clk         in   clock
//   rst         in   synchronous active-high reset (RAM contents are kept)
//   req_valid   in   core presents a request
//   req_ready   out  responder is idle and accepts a request this cycle
//   req_we      in   1 = store, 0 = load
//   req_addr    in   byte address
//   req_wdata   in   store data
//   req_be      in   store byte enables (ignored for loads)
//   resp_valid  out  response available
//   resp_ready  in   core takes the response
//   resp_rdata  out  load data; 0 for stores and errors
//   resp_err    out  request was misaligned or outside the memory window
//
// Timing: counting the accept cycle as cycle 0, resp_valid is high in cycle
// WAIT_CYCLES+2 (WAIT_CYCLES wait cycles, one ACCESS cycle, then RESP).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [WORD_BITS-1:0]      req_addr,
    input  logic [WORD_BITS-1:0]      req_wdata,
    input  logic [BYTES_PER_WORD-1:0] req_be,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [WORD_BITS-1:0]      resp_rdata,
    output logic                      resp_err
);

    // ------------------------------------------------------------------
    // Configuration checks
    // ------------------------------------------------------------------
    if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base_align
        $fatal(1, "dmem_responder: BASE_ADDR must be 4-byte aligned");
    end
    if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 29) begin : g_bad_depth
        $fatal(1, "dmem_responder: DEPTH_LOG2 out of range");
    end
    if (region_end(BASE_ADDR, DEPTH_LOG2) > {1'b1, {WORD_BITS{1'b0}}}) begin : g_bad_wrap
        $fatal(1, "dmem_responder: BASE_ADDR + memory size wraps past 2^32");
    end
    if (WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait
        $fatal(1, "dmem_responder: WAIT_CYCLES must be 0..15");
    end

    localparam logic [WAIT_CNT_BITS-1:0] WAIT_ONE  = WAIT_CNT_BITS'(1);
    localparam logic [WAIT_CNT_BITS-1:0] WAIT_LOAD =
        (WAIT_CYCLES == 0) ? '0 : WAIT_CNT_BITS'(WAIT_CYCLES - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    dmem_state_e              state_q, state_d;
    logic [WAIT_CNT_BITS-1:0] wait_cnt_q, wait_cnt_d;
    dmem_req_t                req_q, req_d;
    logic                     err_q, err_d;

    // ------------------------------------------------------------------
    // Address decode for the latched request
    // ------------------------------------------------------------------
    logic [WORD_BITS-1:0]      offset;
    logic [DEPTH_LOG2-1:0]     word_idx;
    logic                      access_err;
    logic                      ram_en;
    logic [BYTES_PER_WORD-1:0] ram_wen;
    logic [WORD_BITS-1:0]      ram_rdata;

    assign offset     = req_q.addr - BASE_ADDR;
    // Truncation only matters for in-range addresses; out-of-range ones are
    // flagged by access_err and never reach the RAM.
    assign word_idx   = DEPTH_LOG2'(offset >> 2);
    assign access_err = (req_q.addr[1:0] != 2'b00)
                     || !addr_in_range(req_q.addr, BASE_ADDR, DEPTH_LOG2);

    // rst gates the enable so a store whose ACCESS edge meets reset is dropped.
    assign ram_en  = (state_q == StAccess) && !access_err && !rst;
    assign ram_wen = (ram_en && req_q.we) ? req_q.be : '0;

    dmem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .en    (ram_en),
        .wen   (ram_wen),
        .addr  (word_idx),
        .wdata (req_q.wdata),
        .rdata (ram_rdata)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        req_d      = req_q;
        err_d      = err_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    req_d.we    = req_we;
                    req_d.addr  = req_addr;
                    req_d.wdata = req_wdata;
                    req_d.be    = req_be;
                    if (WAIT_CYCLES > 0) begin
                        state_d    = StWait;
                        wait_cnt_d = WAIT_LOAD;
                    end else begin
                        state_d = StAccess;
                    end
                end
            end
            StWait: begin
                if (wait_cnt_q == '0) begin
                    state_d = StAccess;
                end else begin
                    wait_cnt_d = wait_cnt_q - WAIT_ONE;
                end
            end
            StAccess: begin
                // RAM is enabled this cycle; its registered output is valid in RESP.
                err_d   = access_err;
                state_d = StResp;
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            req_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            req_q      <= req_d;
            err_q      <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The RAM output register only changes in ACCESS, so rdata is stable for
    // the whole RESP phase however long the core stalls.
    always_comb begin
        req_ready  = (state_q == StIdle);
        resp_valid = (state_q == StResp);
        resp_err   = resp_valid && err_q;
        resp_rdata = (resp_valid && !err_q && !req_q.we) ? ram_rdata : '0;
    end

    // ------------------------------------------------------------------
    // Simulation checks
    // ------------------------------------------------------------------
    a_resp_hold: assert property (@(posedge clk) disable iff (rst)
        resp_valid && !resp_ready |=> resp_valid && $stable(resp_rdata) && $stable(resp_err));

    a_wait_bound: assert property (@(posedge clk) disable iff (rst)
        state_q == StWait |-> 32'(wait_cnt_q) < WAIT_CYCLES);

    a_err_no_data: assert property (@(posedge clk) disable iff (rst)
        resp_err |-> resp_rdata == '0);

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: one instance with two wait states,
// one with none, both at base address 0 with 1024 words.
module tb_dmem_responder;

    localparam int unsigned DL    = 10;
    localparam int unsigned WORDS = 1 << DL;
    localparam int D_W0 = 0;
    localparam int D_W2 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst, req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
    logic [1:0][31:0] req_addr, req_wdata, resp_rdata;
    logic [1:0][3:0]  req_be;

    dmem_responder #(.DEPTH_LOG2(DL), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .rst(rst[D_W2]), .req_valid(req_valid[D_W2]), .req_ready(req_ready[D_W2]),
        .req_we(req_we[D_W2]), .req_addr(req_addr[D_W2]), .req_wdata(req_wdata[D_W2]),
        .req_be(req_be[D_W2]), .resp_valid(resp_valid[D_W2]), .resp_ready(resp_ready[D_W2]),
        .resp_rdata(resp_rdata[D_W2]), .resp_err(resp_err[D_W2])
    );

    dmem_responder #(.DEPTH_LOG2(DL), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst[D_W0]), .req_valid(req_valid[D_W0]), .req_ready(req_ready[D_W0]),
        .req_we(req_we[D_W0]), .req_addr(req_addr[D_W0]), .req_wdata(req_wdata[D_W0]),
        .req_be(req_be[D_W0]), .resp_valid(resp_valid[D_W0]), .resp_ready(resp_ready[D_W0]),
        .resp_rdata(resp_rdata[D_W0]), .resp_err(resp_err[D_W0])
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Reference memory: a flat word array per instance, updated by the rules
    // "aligned and inside 4 KiB -> merge enabled bytes / return word, else error".
    logic [31:0] mdl [2][WORDS];

    task automatic model_txn(input int d, input logic we, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] be,
                             output logic err, output logic [31:0] rd);
        int unsigned idx;
        err = (a % 4 != 0) || (a / 4 >= WORDS);
        rd  = '0;
        if (!err) begin
            idx = a / 4;
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mdl[d][idx][8*i +: 8] = wd[8*i +: 8];
                end
            end else begin
                rd = mdl[d][idx];
            end
        end
    endtask

    function automatic int wait_of(input int d);
        return (d == D_W2) ? 2 : 0;
    endfunction

    // Entered and left at a falling edge. lat counts cycles from the accept
    // cycle to the first cycle with resp_valid high.
    task automatic txn(input int d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input bit tie_rr,
                       output logic [31:0] rd, output logic err, output int lat,
                       output time t_acc, output bit ok);
        int n;
        ok = 1'b1; n = 0; lat = 0; rd = 'x; err = 1'bx; t_acc = 0;
        while (req_ready[d] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin ok = 1'b0; return; end
        req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = a; req_wdata[d] = wd; req_be[d] = be;
        t_acc = $time;
        @(negedge clk);
        // Junk on the request bus while busy must not matter.
        req_valid[d] = 1'b0; req_we[d] = 1'($urandom); req_addr[d] = $urandom;
        req_wdata[d] = $urandom; req_be[d] = 4'($urandom);
        lat = 1;
        while (resp_valid[d] !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
        if (lat >= 50) begin ok = 1'b0; return; end
        rd = resp_rdata[d];
        err = resp_err[d];
        resp_ready[d] = 1'b1;
        @(negedge clk);
        if (!tie_rr) resp_ready[d] = 1'b0;
    endtask

    // Transaction checked against the reference model.
    task automatic run_model(input int d, input string tag, input logic we, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] be, input bit tie_rr,
                             output time t_acc);
        logic [31:0] rd, exp_rd;
        logic err, exp_err;
        int lat;
        bit ok;
        txn(d, we, a, wd, be, tie_rr, rd, err, lat, t_acc, ok);
        model_txn(d, we, a, wd, be, exp_err, exp_rd);
        check1({tag, "_handshake"}, ok, 1'b1);
        check1({tag, "_err"}, err, exp_err);
        check32({tag, "_rdata"}, rd, exp_rd);
        check_int({tag, "_latency"}, lat, wait_of(d) + 2);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, input logic e, input logic [31:0] r);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = wd; v.be = be; v.exp_err = e; v.exp_rdata = r;
        vecs.push_back(v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, a, held;
        logic err, dummy_e;
        logic [31:0] dummy_r;
        int lat, n;
        bit ok;
        time t_acc, t_prev;

        for (int d = 0; d < 2; d++) for (int i = 0; i < WORDS; i++) mdl[d][i] = '0;

        // Directed vectors for the two-wait-state instance.
        add_vec(1'b1, 32'h10,       32'hDEADBEEF, 4'hF,    1'b0, 32'h0);
        add_vec(1'b0, 32'h10,       32'h0,        4'hF,    1'b0, 32'hDEADBEEF);
        add_vec(1'b1, 32'h10,       32'h00000055, 4'b0001, 1'b0, 32'h0);
        add_vec(1'b0, 32'h10,       32'h0,        4'hF,    1'b0, 32'hDEADBE55);
        add_vec(1'b1, 32'h10,       32'hFFFFFFFF, 4'h0,    1'b0, 32'h0);
        add_vec(1'b0, 32'h10,       32'h0,        4'hF,    1'b0, 32'hDEADBE55);
        add_vec(1'b0, 32'h12,       32'h0,        4'hF,    1'b1, 32'h0);
        add_vec(1'b1, 32'h0,        32'h01020304, 4'hF,    1'b0, 32'h0);
        add_vec(1'b1, 32'h1000,     32'hAAAAAAAA, 4'hF,    1'b1, 32'h0);
        add_vec(1'b0, 32'h0,        32'h0,        4'hF,    1'b0, 32'h01020304);
        add_vec(1'b1, 32'h13,       32'h11111111, 4'hF,    1'b1, 32'h0);
        add_vec(1'b0, 32'h10,       32'h0,        4'hF,    1'b0, 32'hDEADBE55);
        add_vec(1'b1, 32'hFFC,      32'hCAFEF00D, 4'b1100, 1'b0, 32'h0);
        add_vec(1'b0, 32'hFFC,      32'h0,        4'hF,    1'b0, 32'hCAFE0000);
        add_vec(1'b0, 32'hFFFFFFFC, 32'h0,        4'hF,    1'b1, 32'h0);
        add_vec(1'b0, 32'h10,       32'h0,        4'h0,    1'b0, 32'hDEADBE55);

        rst = 2'b11; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_be = '0;
        resp_ready = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check1("reset_req_ready", req_ready[d], 1'b1);
            check1("reset_resp_valid", resp_valid[d], 1'b0);
            check32("reset_resp_rdata", resp_rdata[d], 32'h0);
            check1("reset_resp_err", resp_err[d], 1'b0);
        end
        rst = 2'b00;
        @(negedge clk);

        // Table-driven phase.
        foreach (vecs[i]) begin
            txn(D_W2, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, 1'b0,
                rd, err, lat, t_acc, ok);
            model_txn(D_W2, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, dummy_e, dummy_r);
            check1($sformatf("vec%0d_handshake", i), ok, 1'b1);
            check1($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
            check32($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check_int($sformatf("vec%0d_latency", i), lat, 4);
        end

        // Backpressure: response held for 5 cycles while a competing store waits.
        req_valid[D_W2] = 1'b1; req_we[D_W2] = 1'b0; req_addr[D_W2] = 32'h10; req_be[D_W2] = 4'hF;
        @(negedge clk);
        req_valid[D_W2] = 1'b0;
        n = 0;
        while (resp_valid[D_W2] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check1("bp_resp_arrives", n < 50, 1'b1);
        held = resp_rdata[D_W2];
        check32("bp_first_rdata", held, 32'hDEADBE55);
        req_valid[D_W2] = 1'b1; req_we[D_W2] = 1'b1; req_addr[D_W2] = 32'h10;
        req_wdata[D_W2] = 32'h0; req_be[D_W2] = 4'hF;
        for (int i = 0; i < 5; i++) begin
            check1("bp_resp_valid", resp_valid[D_W2], 1'b1);
            check32("bp_resp_rdata", resp_rdata[D_W2], 32'hDEADBE55);
            check1("bp_req_ready", req_ready[D_W2], 1'b0);
            @(negedge clk);
        end
        req_valid[D_W2] = 1'b0;
        resp_ready[D_W2] = 1'b1;
        @(negedge clk);
        resp_ready[D_W2] = 1'b0;
        check1("bp_req_ready_after", req_ready[D_W2], 1'b1);
        check1("bp_resp_valid_after", resp_valid[D_W2], 1'b0);
        run_model(D_W2, "bp_ignored_store", 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, t_acc);

        // Reset during WAIT abandons the store.
        req_valid[D_W2] = 1'b1; req_we[D_W2] = 1'b1; req_addr[D_W2] = 32'h20;
        req_wdata[D_W2] = 32'h12345678; req_be[D_W2] = 4'hF;
        @(negedge clk);
        req_valid[D_W2] = 1'b0;
        rst[D_W2] = 1'b1;
        @(negedge clk);
        rst[D_W2] = 1'b0;
        check1("rstwait_req_ready", req_ready[D_W2], 1'b1);
        check1("rstwait_resp_valid", resp_valid[D_W2], 1'b0);
        check32("rstwait_resp_rdata", resp_rdata[D_W2], 32'h0);
        check1("rstwait_resp_err", resp_err[D_W2], 1'b0);
        repeat (5) @(negedge clk);
        check1("rstwait_no_late_resp", resp_valid[D_W2], 1'b0);
        txn(D_W2, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, rd, err, lat, t_acc, ok);
        check1("rstwait_load_ok", ok, 1'b1);
        check32("rstwait_load_0x20", rd, 32'h0);

        // Reset on the ACCESS edge with no wait states: store still dropped.
        req_valid[D_W0] = 1'b1; req_we[D_W0] = 1'b1; req_addr[D_W0] = 32'h20;
        req_wdata[D_W0] = 32'h12345678; req_be[D_W0] = 4'hF;
        @(negedge clk);
        req_valid[D_W0] = 1'b0;
        rst[D_W0] = 1'b1;
        @(negedge clk);
        rst[D_W0] = 1'b0;
        check1("rstacc_req_ready", req_ready[D_W0], 1'b1);
        check1("rstacc_resp_valid", resp_valid[D_W0], 1'b0);
        check32("rstacc_resp_rdata", resp_rdata[D_W0], 32'h0);
        txn(D_W0, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, rd, err, lat, t_acc, ok);
        check1("rstacc_load_ok", ok, 1'b1);
        check32("rstacc_load_0x20", rd, 32'h0);

        // Back-to-back with resp_ready tied high: one transaction per 3 cycles.
        resp_ready[D_W0] = 1'b1;
        t_prev = 0;
        for (int i = 0; i < 16; i++) begin
            a = 4 * $urandom_range(0, 7);
            run_model(D_W0, "b2b", (i % 2 == 0), a, $urandom, 4'($urandom), 1'b1, t_acc);
            if (i > 0) check_int("b2b_spacing_ns", int'(t_acc - t_prev), 30);
            t_prev = t_acc;
        end
        resp_ready[D_W0] = 1'b0;

        // Randomized traffic on both instances against the reference model.
        for (int i = 0; i < 80; i++) begin
            int d;
            d = (i % 2 == 0) ? D_W2 : D_W0;
            case ($urandom_range(0, 5))
                0, 1, 2: a = 4 * $urandom_range(0, 15);
                3:       a = 4 * $urandom_range(0, WORDS - 1);
                4:       a = 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
                default: a = $urandom | 32'h0000_1000;
            endcase
            run_model(d, "rand", 1'($urandom), a, $urandom, 4'($urandom), 1'b0, t_acc);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
